// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: pops an upstream FIFO with one-cycle read latency and forwards
// words downstream over a valid/ready handshake through a 2-entry skid buffer.
// A small IDLE/ACTIVE/FLUSH state machine gates popping, and a wrapping
// counter tracks how many words the downstream side has accepted.
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 6,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  RESET_L,
    input  logic                  active_in,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic                  idle_out,
    output logic [CNT_WIDTH-1:0]  count_out
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] FLUSH  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic [1:0]            bufCnt_q, bufCnt_d;
    logic                  inflight_q;
    logic [CNT_WIDTH-1:0]  count_q, count_d;

    logic [1:0]            occupancy;
    logic                  transfer;

    // Occupancy counts buffered words plus the pop whose data lands this cycle,
    // so a pop is only issued when there is guaranteed room for its data.
    always_comb begin
        valid_out = (bufCnt_q != 2'd0);
        transfer  = valid_out && ready_in;
        occupancy = bufCnt_q + {1'b0, inflight_q};
        fifo_rd   = (state_q == ACTIVE) && !fifo_empty &&
                    ((occupancy - {1'b0, transfer}) < 2'd2);
        data_out  = buf0_q;
        idle_out  = (state_q == IDLE);
        count_out = count_q;
    end

    // Skid buffer: buf0 is always the head; capture and transfer in the same
    // cycle shift the queue so order and occupancy are preserved.
    always_comb begin
        buf0_d   = buf0_q;
        buf1_d   = buf1_q;
        bufCnt_d = bufCnt_q;
        case ({inflight_q, transfer})
            2'b11: begin
                if (bufCnt_q == 2'd2) begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_data;
                end else begin
                    buf0_d = fifo_data;
                end
            end
            2'b10: begin
                if (bufCnt_q == 2'd0) begin
                    buf0_d = fifo_data;
                end else begin
                    buf1_d = fifo_data;
                end
                bufCnt_d = bufCnt_q + 2'd1;
            end
            2'b01: begin
                buf0_d   = buf1_q;
                bufCnt_d = bufCnt_q - 2'd1;
            end
            default: ;
        endcase
    end

    // Accepted-word counter wraps silently at its width.
    always_comb begin
        count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, transfer};
    end

    // Mode control: FLUSH drains whatever is already buffered or in flight
    // without issuing new pops, and can be re-entered into ACTIVE at any time.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (active_in) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!active_in) begin
                    state_d = (occupancy != 2'd0) ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                if (active_in) begin
                    state_d = ACTIVE;
                end else if (occupancy == 2'd0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops buffered words and any pop still in flight.
    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q    <= IDLE;
            buf0_q     <= '0;
            buf1_q     <= '0;
            bufCnt_q   <= 2'd0;
            inflight_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            bufCnt_q   <= bufCnt_d;
            inflight_q <= fifo_rd;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: drives fifo_rd_ctrl from a behavioural upstream FIFO and
// checks directed vectors, corner-case sequences and a randomized run against
// an in-order delivery scoreboard.
module tb_fifo_rd_ctrl;

    localparam int DW    = 6;
    localparam int CW    = 8;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          RESET_L = 1'b1;
    logic          active_in = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          ready_in = 1'b0;
    logic          idle_out;
    logic [CW-1:0] count_out;

    int checks   = 0;
    int failures = 0;

    // Upstream FIFO: words pushed by the stimulus, popped with one-cycle latency
    logic [DW-1:0] mem [DEPTH];
    int wrPtr = 0;
    int rdPtr;

    // Scoreboard state, owned by the monitor process
    int            expIdx = 0;
    logic [CW-1:0] modelCount = '0;
    bit            prevHold = 1'b0;
    logic [DW-1:0] prevData = '0;

    int xfers;
    int pops;

    typedef struct packed {
        bit          doReset;
        bit          pushEn;
        logic [5:0]  pushWord;
        bit          activeIn;
        bit          readyIn;
        bit          expRd;
        bit          expValid;
        logic [5:0]  expData;
        bit          expIdle;
        logic [7:0]  expCount;
    } vec_t;

    vec_t vecs [13];

    always #5 clk = ~clk;

    fifo_rd_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .RESET_L    (RESET_L),
        .active_in  (active_in),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .idle_out   (idle_out),
        .count_out  (count_out)
    );

    assign fifo_empty = (wrPtr == rdPtr);

    // Upstream FIFO read port
    always @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            rdPtr     <= 0;
            fifo_data <= '0;
        end else if (fifo_rd && (rdPtr != wrPtr)) begin
            fifo_data <= mem[rdPtr[11:0]];
            rdPtr     <= rdPtr + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pushWord(input logic [DW-1:0] w);
        if (wrPtr < DEPTH) begin
            mem[wrPtr[11:0]] = w;
            wrPtr++;
        end
    endtask

    // Leaves the bench at a falling edge with reset just released
    task automatic pulseReset();
        RESET_L   = 1'b0;
        wrPtr     = 0;
        active_in = 1'b0;
        ready_in  = 1'b0;
        repeat (2) @(negedge clk);
        RESET_L = 1'b1;
    endtask

    // Every word accepted downstream must be the next word pushed upstream,
    // the counter must track acceptances, stalled data must hold, no pop may
    // hit an empty FIFO, and no more than two words may be outstanding.
    task automatic monitorLoop();
        forever begin
            @(negedge clk);
            #2;
            if (!RESET_L) begin
                expIdx     = 0;
                modelCount = '0;
                prevHold   = 1'b0;
            end else begin
                check("mon_count", int'(count_out), int'(modelCount));
                if (fifo_rd && fifo_empty) begin
                    check("mon_pop_on_empty", 1, 0);
                end
                if (rdPtr - expIdx > 2) begin
                    check("mon_occupancy", rdPtr - expIdx, 2);
                end
                if (prevHold) begin
                    check("mon_hold_valid", int'(valid_out), 1);
                    check("mon_hold_data", int'(data_out), int'(prevData));
                end
                if (valid_out && ready_in) begin
                    if (expIdx < wrPtr) begin
                        check("mon_order", int'(data_out), int'(mem[expIdx[11:0]]));
                    end else begin
                        check("mon_spurious", expIdx, wrPtr - 1);
                    end
                    expIdx++;
                    modelCount = modelCount + 8'd1;
                end
                prevHold = valid_out && !ready_in;
                prevData = data_out;
            end
        end
    endtask

    task automatic checkOutput(input int i);
        check($sformatf("row%0d_rd", i), int'(fifo_rd), int'(vecs[i].expRd));
        check($sformatf("row%0d_valid", i), int'(valid_out), int'(vecs[i].expValid));
        if (vecs[i].expValid) begin
            check($sformatf("row%0d_data", i), int'(data_out), int'(vecs[i].expData));
        end
        check($sformatf("row%0d_idle", i), int'(idle_out), int'(vecs[i].expIdle));
        check($sformatf("row%0d_count", i), int'(count_out), int'(vecs[i].expCount));
    endtask

    task automatic applyStimulus(input int i);
        if (vecs[i].doReset) begin
            pulseReset();
        end else begin
            @(negedge clk);
        end
        if (vecs[i].pushEn) begin
            pushWord(vecs[i].pushWord);
        end
        active_in = vecs[i].activeIn;
        ready_in  = vecs[i].readyIn;
        #1;
        checkOutput(i);
    endtask

    initial begin
        // Single preloaded word: pop at cycle 1, valid at cycle 3
        vecs[0]  = '{1'b1, 1'b1, 6'b010010, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 1'b1, 8'd0};
        vecs[1]  = '{1'b0, 1'b0, 6'b000000, 1'b1, 1'b1, 1'b1, 1'b0, 6'b000000, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 1'b0, 6'b000000, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 1'b0, 6'b000000, 1'b1, 1'b1, 1'b0, 1'b1, 6'b010010, 1'b0, 8'd0};
        vecs[4]  = '{1'b0, 1'b0, 6'b000000, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 1'b0, 8'd1};
        // Four words streamed back to back
        vecs[5]  = '{1'b1, 1'b1, 6'b100100, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 1'b1, 8'd0};
        vecs[6]  = '{1'b0, 1'b1, 6'b110110, 1'b1, 1'b1, 1'b1, 1'b0, 6'b000000, 1'b0, 8'd0};
        vecs[7]  = '{1'b0, 1'b1, 6'b010100, 1'b1, 1'b1, 1'b1, 1'b0, 6'b000000, 1'b0, 8'd0};
        vecs[8]  = '{1'b0, 1'b1, 6'b110000, 1'b1, 1'b1, 1'b1, 1'b1, 6'b100100, 1'b0, 8'd0};
        vecs[9]  = '{1'b0, 1'b0, 6'b000000, 1'b1, 1'b1, 1'b1, 1'b1, 6'b110110, 1'b0, 8'd1};
        vecs[10] = '{1'b0, 1'b0, 6'b000000, 1'b1, 1'b1, 1'b0, 1'b1, 6'b010100, 1'b0, 8'd2};
        vecs[11] = '{1'b0, 1'b0, 6'b000000, 1'b1, 1'b1, 1'b0, 1'b1, 6'b110000, 1'b0, 8'd3};
        vecs[12] = '{1'b0, 1'b0, 6'b000000, 1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 1'b0, 8'd4};

        fork
            monitorLoop();
        join_none

        // Reset values
        #1;
        RESET_L = 1'b0;
        #1;
        check("rst_valid", int'(valid_out), 0);
        check("rst_data", int'(data_out), 0);
        check("rst_rd", int'(fifo_rd), 0);
        check("rst_idle", int'(idle_out), 1);
        check("rst_count", int'(count_out), 0);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(i);
        end

        // Stalled downstream: only two pops, head held, then drained in order
        pulseReset();
        pushWord(6'b100100);
        pushWord(6'b110110);
        pushWord(6'b010100);
        pushWord(6'b110000);
        active_in = 1'b1;
        ready_in  = 1'b0;
        pops = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            if (fifo_rd) pops++;
        end
        check("stall_pops", pops, 2);
        check("stall_valid", int'(valid_out), 1);
        check("stall_data", int'(data_out), int'(6'b100100));
        ready_in = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
        end
        check("stall_count", int'(count_out), 4);
        check("stall_delivered", expIdx, 4);
        check("stall_drained_valid", int'(valid_out), 0);
        check("stall_fifo_empty", int'(fifo_empty), 1);

        // Deactivate with two words buffered: flush without popping
        pulseReset();
        pushWord(6'b100100);
        pushWord(6'b110110);
        pushWord(6'b010100);
        pushWord(6'b110000);
        active_in = 1'b1;
        ready_in  = 1'b0;
        repeat (4) @(negedge clk);
        active_in = 1'b0;
        #1;
        check("flush_entry_rd", int'(fifo_rd), 0);
        check("flush_entry_valid", int'(valid_out), 1);
        check("flush_entry_data", int'(data_out), int'(6'b100100));
        @(negedge clk);
        ready_in = 1'b1;
        #1;
        check("flush_not_idle", int'(idle_out), 0);
        pops = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (fifo_rd) pops++;
        end
        check("flush_no_pops", pops, 0);
        check("flush_idle", int'(idle_out), 1);
        check("flush_count", int'(count_out), 2);
        check("flush_delivered", expIdx, 2);

        // Counter wrap after 256 transfers, then asynchronous reset mid-stream
        pulseReset();
        for (int i = 0; i < 260; i++) begin
            pushWord(6'(i * 7 + 3));
        end
        active_in = 1'b1;
        ready_in  = 1'b1;
        xfers = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            #1;
            if (xfers == 256) break;
            if (valid_out && ready_in) xfers++;
        end
        check("wrap_reached", xfers, 256);
        check("wrap_count", int'(count_out), 0);
        check("wrap_valid", int'(valid_out), 1);
        #2;
        RESET_L = 1'b0;
        #1;
        check("midrst_valid", int'(valid_out), 0);
        check("midrst_data", int'(data_out), 0);
        check("midrst_rd", int'(fifo_rd), 0);
        check("midrst_idle", int'(idle_out), 1);
        check("midrst_count", int'(count_out), 0);
        pulseReset();
        active_in = 1'b1;
        pushWord(6'b111111);
        #1;
        check("postrst_first_rd", int'(fifo_rd), 0);

        // Randomized traffic, activity toggling and backpressure
        pulseReset();
        active_in = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (($urandom % 2) == 0) pushWord(6'($urandom));
            ready_in = (($urandom % 4) != 0);
            if (($urandom % 8) == 0) active_in = ~active_in;
        end
        @(negedge clk);
        active_in = 1'b1;
        ready_in  = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            if (expIdx == wrPtr) break;
        end
        check("rand_all_delivered", expIdx, wrPtr);
        @(negedge clk);
        #1;
        check("rand_drained_valid", int'(valid_out), 0);
        check("rand_count", int'(count_out), int'(modelCount));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 6, width of the FIFO word and of the forwarded word.
REQ-002 Parameter CNT_WIDTH, default 8, width of the forwarded-word counter.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port RESET_L  input  1  reset, asynchronous, active-low.
REQ-005 Port active_in  input  1  enables popping from the upstream FIFO.
REQ-006 Port fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 Port fifo_data  input  DATA_WIDTH  upstream FIFO read data, valid the cycle after fifo_rd was high.
REQ-008 Port fifo_rd  output  1  pop request to the upstream FIFO.
REQ-009 Port data_out  output  DATA_WIDTH  forwarded word.
REQ-010 Port valid_out  output  1  data_out holds a valid word.
REQ-011 Port ready_in  input  1  downstream accepts data_out this cycle.
REQ-012 Port idle_out  output  1  high in IDLE state.
REQ-013 Port count_out  output  CNT_WIDTH  number of words accepted downstream.

Function
REQ-014 Transfer to downstream SHALL occur on a rising edge where valid_out && ready_in; data_out SHALL be held stable while valid_out && !ready_in.
REQ-015 Block SHALL contain a 2-entry in-order skid buffer; occupancy = buffered words + pops in flight (fifo_rd high last cycle).
REQ-016 fifo_rd SHALL be combinationally high only when state==ACTIVE, !fifo_empty, and occupancy minus (transfer this cycle ? 1 : 0) < 2.
REQ-017 fifo_data SHALL be captured into the buffer on the edge one cycle after fifo_rd was high, regardless of state.
REQ-018 Buffer head SHALL drive data_out; valid_out SHALL equal buffer-not-empty (registered state, no combinational path from fifo_data).
REQ-019 Simultaneous capture and transfer SHALL keep order and occupancy unchanged; capture into a full buffer SHALL never occur (guaranteed by REQ-016).
REQ-020 Sustained throughput SHALL be one word per cycle while FIFO non-empty and ready_in high; first word latency: fifo_rd at cycle N -> valid_out at N+2.
REQ-021 States: IDLE, ACTIVE, FLUSH; encoding free.
REQ-022 IDLE -> ACTIVE when active_in=1; ACTIVE -> FLUSH when active_in=0 and occupancy>0; ACTIVE -> IDLE when active_in=0 and occupancy==0.
REQ-023 FLUSH: no fifo_rd; -> IDLE when occupancy reaches 0; -> ACTIVE if active_in returns to 1.
REQ-024 count_out SHALL increment by 1 per transfer and wrap from 2^CNT_WIDTH-1 to 0 with no flag.
REQ-025 Empty toggling: fifo_rd SHALL drop in the same cycle fifo_empty rises; no pop is ever issued while fifo_empty=1.

Reset
REQ-026 RESET_L low SHALL immediately force state=IDLE, buffer empty, in-flight pop discarded, count_out=0, valid_out=0, data_out=0, fifo_rd=0, idle_out=1.
REQ-027 Reset asserted mid-transfer SHALL drop any buffered word; first fifo_rd after release no earlier than the first edge with active_in=1 sampled.

Verification
REQ-028 Reset, active_in=1, FIFO preloaded 6'b010010, ready_in=1 -> fifo_rd one cycle, valid_out 2 cycles later with data_out=6'b010010, count_out=1.
REQ-029 FIFO holds 100100,110110,010100,110000, ready_in=1 -> four back-to-back valid cycles in order, count_out=4, fifo_rd low once fifo_empty=1.
REQ-030 Same four words, ready_in=0 -> exactly two pops, valid_out high with data_out=100100 held; ready_in=1 -> remaining words in order, no loss or duplication.
REQ-031 active_in dropped with 2 words buffered -> state FLUSH, no fifo_rd, both words delivered, then idle_out=1.
REQ-032 256 transfers with CNT_WIDTH=8 -> count_out wraps to 0; RESET_L pulsed low mid-stream with valid_out high -> all outputs at reset values within the same cycle.
